// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: accumulator FSM states and adder group size.
package arith_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accum_state_e;

  localparam int unsigned CLA_WIDTH = 4;

endpackage

// File: rtl/accum_unit_if.sv
// Sample-in / result-out valid-ready bus for accum_unit.
interface accum_unit_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/adder.sv
// Unsigned adder with carry-out: ALGORITHM 0 = ripple-carry, 1 = 4-bit carry-look-ahead groups.
module adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned ALGORITHM = 0
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH:0]   sum
);

  if (ALGORITHM == 1) begin : g_cla
    // Lookahead inside each 4-bit group, groups chained by their carry-out.
    always_comb begin : cla
      logic                 cin;
      logic [CLA_WIDTH-1:0] p;
      logic [CLA_WIDTH-1:0] g;
      logic [CLA_WIDTH:0]   c;
      cin = 1'b0;
      p   = '0;
      g   = '0;
      c   = '0;
      sum = '0;
      for (int unsigned k = 0; k < WIDTH / CLA_WIDTH; k++) begin
        p    = in0[CLA_WIDTH*k +: CLA_WIDTH] ^ in1[CLA_WIDTH*k +: CLA_WIDTH];
        g    = in0[CLA_WIDTH*k +: CLA_WIDTH] & in1[CLA_WIDTH*k +: CLA_WIDTH];
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum[CLA_WIDTH*k +: CLA_WIDTH] = p ^ c[CLA_WIDTH-1:0];
        cin = c[CLA_WIDTH];
      end
      sum[WIDTH] = cin;
    end
  end else begin : g_ripple
    always_comb begin : ripple
      logic carry;
      carry = 1'b0;
      sum   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        sum[i] = in0[i] ^ in1[i] ^ carry;
        carry  = (in0[i] & in1[i]) | (carry & (in0[i] ^ in1[i]));
      end
      sum[WIDTH] = carry;
    end
  end

endmodule

// File: rtl/accum_unit.sv
// Frame accumulator: sums COUNT samples, presents total + sticky overflow over valid/ready.
// Optional ACCUM_SAT_EN: saturate the accumulator to all-ones on carry-out instead of wrapping.
module accum_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned COUNT     = 8,
  parameter int unsigned ALGORITHM = 0
) (
  input logic         clk,
  input logic         rst,
  accum_unit_if.slave bus
);

  if (ACC_WIDTH < WIDTH) begin : g_chk_width
    $error("accum_unit: ACC_WIDTH must be >= WIDTH");
  end
  if (COUNT < 1) begin : g_chk_count
    $error("accum_unit: COUNT must be >= 1");
  end
  if (ALGORITHM == 1 && (ACC_WIDTH % CLA_WIDTH) != 0) begin : g_chk_cla
    $error("accum_unit: carry-look-ahead needs ACC_WIDTH to be a multiple of 4");
  end

  localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  accum_state_e         state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic                 in_rdy;
  logic                 res_valid;
  logic [ACC_WIDTH-1:0] res_data;
  logic                 res_ovf;

  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 last;

  assign sample = ACC_WIDTH'(bus.in_data);
  assign last   = (cnt == CNT_W'(COUNT - 1));

  adder #(
    .WIDTH    (ACC_WIDTH),
    .ALGORITHM(ALGORITHM)
  ) u_adder (
    .in0(acc),
    .in1(sample),
    .sum(sum)
  );

`ifdef ACCUM_SAT_EN
  // Once saturated, any further nonzero sample carries again, so all-ones is sticky.
  assign acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
  assign acc_next = sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_rdy    <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            if (last) begin
              res_data  <= acc_next;
              res_ovf   <= ovf | sum[ACC_WIDTH];
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              in_rdy    <= 1'b0;
              res_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              ovf <= ovf | sum[ACC_WIDTH];
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            in_rdy    <= 1'b1;
            res_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;
  assign bus.out_ovf   = res_ovf;

endmodule

// File: tb/tb_accum_unit.sv
// Directed bench for accum_unit: several configurations driven from one linear sequence.
module tb_accum_unit;

  logic clk;
  logic rst;
  int unsigned errors;
  int unsigned checks;

  accum_unit_if #(.WIDTH(16), .ACC_WIDTH(24)) ia ();
  accum_unit_if #(.WIDTH(16), .ACC_WIDTH(24)) id ();
  accum_unit_if #(.WIDTH(8),  .ACC_WIDTH(8))  ib ();
  accum_unit_if #(.WIDTH(8),  .ACC_WIDTH(8))  ib2 ();
  accum_unit_if #(.WIDTH(16), .ACC_WIDTH(24)) ic ();

  // Carry-look-ahead copies see exactly the same stimulus as their ripple twins.
  assign id.in_valid   = ia.in_valid;
  assign id.in_data    = ia.in_data;
  assign id.out_ready  = ia.out_ready;
  assign ib2.in_valid  = ib.in_valid;
  assign ib2.in_data   = ib.in_data;
  assign ib2.out_ready = ib.out_ready;

  accum_unit #(.WIDTH(16), .ACC_WIDTH(24), .COUNT(4), .ALGORITHM(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  accum_unit #(.WIDTH(16), .ACC_WIDTH(24), .COUNT(4), .ALGORITHM(1)) dut_d (.clk(clk), .rst(rst), .bus(id));
  accum_unit #(.WIDTH(8),  .ACC_WIDTH(8),  .COUNT(2), .ALGORITHM(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  accum_unit #(.WIDTH(8),  .ACC_WIDTH(8),  .COUNT(2), .ALGORITHM(1)) dut_b2 (.clk(clk), .rst(rst), .bus(ib2));
  accum_unit #(.WIDTH(16), .ACC_WIDTH(24), .COUNT(1), .ALGORITHM(0)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef ACCUM_SAT_EN
  localparam logic [7:0] B_OVF_SUM = 8'd255;
`else
  localparam logic [7:0] B_OVF_SUM = 8'd44;
`endif

  initial begin
    logic [23:0] model;
    logic [15:0] v;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b1;
    ic.in_valid = 1'b0; ic.in_data = '0; ic.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_out_data", 32'(ia.out_data), 32'd0);
    chk("rst_out_ovf", 32'(ia.out_ovf), 32'd0);
    rst = 1'b0;

    // Frame 1,2,3,4 back-to-back, downstream always ready
    for (int i = 0; i < 4; i++) begin
      ia.in_valid = 1'b1;
      ia.in_data  = 16'(i + 1);
      tick();
      if (i < 3) chk("a_no_early_valid", 32'(ia.out_valid), 32'd0);
    end
    ia.in_valid = 1'b0;
    chk("a_valid", 32'(ia.out_valid), 32'd1);
    chk("a_sum10", 32'(ia.out_data), 32'd10);
    chk("a_ovf0", 32'(ia.out_ovf), 32'd0);
    chk("a_ready_low", 32'(ia.in_ready), 32'd0);
    chk("d_sum10", 32'(id.out_data), 32'd10);
    tick();
    chk("a_after_xfer_valid", 32'(ia.out_valid), 32'd0);
    chk("a_after_xfer_ready", 32'(ia.in_ready), 32'd1);

    // Same frame with back-pressure; upstream already presents the next frame's data
    ia.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ia.in_valid = 1'b1;
      ia.in_data  = 16'(i + 1);
      tick();
    end
    ia.in_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(ia.out_valid), 32'd1);
      chk("bp_data", 32'(ia.out_data), 32'd10);
      chk("bp_ready", 32'(ia.in_ready), 32'd0);
      tick();
    end
    ia.out_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", 32'(ia.out_valid), 32'd0);
    chk("bp_xfer_ready", 32'(ia.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    ia.in_valid = 1'b0;
    chk("ffff_valid", 32'(ia.out_valid), 32'd1);
    chk("ffff_sum", 32'(ia.out_data), 32'h03FFFC);
    chk("ffff_sum_cla", 32'(id.out_data), 32'h03FFFC);
    chk("ffff_ovf", 32'(ia.out_ovf), 32'd0);
    tick();

    // Reset mid-frame discards 5+6
    ia.in_valid = 1'b1;
    ia.in_data  = 16'd5;
    tick();
    ia.in_data  = 16'd6;
    tick();
    ia.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 32'(ia.in_ready), 32'd1);
    chk("midrst_valid", 32'(ia.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ia.in_valid = 1'b1;
      ia.in_data  = 16'd1;
      tick();
      if (i < 3) chk("midrst_no_early", 32'(ia.out_valid), 32'd0);
    end
    ia.in_valid = 1'b0;
    chk("midrst_sum4", 32'(ia.out_data), 32'd4);
    chk("midrst_ovf", 32'(ia.out_ovf), 32'd0);

    // Reset while holding drops the result
    ia.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.out_ready = 1'b1;
    chk("holdrst_valid", 32'(ia.out_valid), 32'd0);
    chk("holdrst_data", 32'(ia.out_data), 32'd0);
    chk("holdrst_ready", 32'(ia.in_ready), 32'd1);

    // 8-bit accumulator overflow: 200 + 100
    ib.in_valid = 1'b1;
    ib.in_data  = 8'd200;
    tick();
    ib.in_data  = 8'd100;
    tick();
    ib.in_valid = 1'b0;
    chk("b_valid", 32'(ib.out_valid), 32'd1);
    chk("b_ovf_sum", 32'(ib.out_data), 32'(B_OVF_SUM));
    chk("b_ovf_flag", 32'(ib.out_ovf), 32'd1);
    chk("b2_ovf_sum", 32'(ib2.out_data), 32'(B_OVF_SUM));
    chk("b2_ovf_flag", 32'(ib2.out_ovf), 32'd1);
    tick();
    ib.in_valid = 1'b1;
    ib.in_data  = 8'd10;
    tick();
    ib.in_data  = 8'd20;
    tick();
    ib.in_valid = 1'b0;
    chk("b_sum30", 32'(ib.out_data), 32'd30);
    chk("b_ovf_cleared", 32'(ib.out_ovf), 32'd0);
    chk("b2_sum30", 32'(ib2.out_data), 32'd30);
    tick();

    // COUNT=1: each accept is a frame
    ic.in_valid = 1'b1;
    ic.in_data  = 16'd7;
    tick();
    chk("c_valid7", 32'(ic.out_valid), 32'd1);
    chk("c_data7", 32'(ic.out_data), 32'd7);
    chk("c_ready_low", 32'(ic.in_ready), 32'd0);
    ic.in_data  = 16'd9;
    tick();
    chk("c_xfer_valid", 32'(ic.out_valid), 32'd0);
    chk("c_xfer_ready", 32'(ic.in_ready), 32'd1);
    tick();
    ic.in_valid = 1'b0;
    chk("c_valid9", 32'(ic.out_valid), 32'd1);
    chk("c_data9", 32'(ic.out_data), 32'd9);
    tick();
    chk("c_idle", 32'(ic.out_valid), 32'd0);

    // Random data with input gaps; ripple and CLA compared against a running sum
    for (int f = 0; f < 20; f++) begin
      model = '0;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          ia.in_valid = 1'b0;
          tick();
        end
        v = 16'($urandom);
        ia.in_valid = 1'b1;
        ia.in_data  = v;
        model = model + 24'(v);
        tick();
      end
      ia.in_valid = 1'b0;
      chk("rnd_valid", 32'(ia.out_valid), 32'd1);
      chk("rnd_sum", 32'(ia.out_data), 32'(model));
      chk("rnd_sum_cla", 32'(id.out_data), 32'(model));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
